// File: rtl/id_bundle_queue.sv
// Decoded-bundle FIFO between the decoder and the reservation station; 1-cycle minimum latency, no bypass.
// Backpressure: dec_ready drops when full or flushing; a pop from a full queue frees its slot only on the next cycle.
module id_bundle_queue #(
    parameter int          DEPTH = 4,
    parameter int          PTR_W = 2,
    parameter logic [19:0] NOP   = 20'b0000_0000_1111_00_000_000
) (
    input  logic             clk,
    input  logic             a_rst,
    input  logic             flush,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [19:0]      dec_uop_0,
    input  logic [19:0]      dec_uop_1,
    input  logic [19:0]      dec_uop_2,
    input  logic [1:0]       dec_uop_count,
    input  logic [15:0]      dec_k16,
    input  logic             id_feed_req,
    output logic             id_feed_ack,
    output logic [19:0]      id_uop_0,
    output logic [19:0]      id_uop_1,
    output logic [19:0]      id_uop_2,
    output logic [1:0]       id_uop_count,
    output logic [15:0]      id_k16,
    output logic [PTR_W:0]   occupancy
);

    typedef struct packed {
        logic [19:0] uop_0;
        logic [19:0] uop_1;
        logic [19:0] uop_2;
        logic [1:0]  count;
        logic [15:0] k16;
    } bundle_t;

    localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

    bundle_t          mem [DEPTH];
    bundle_t          wr_bundle;
    bundle_t          head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (occ == '0);
    assign full  = (occ == FULL_OCC);

    // Ready depends only on registered state and flush, never on id_feed_req.
    assign dec_ready   = ~full & ~flush;
    assign push        = dec_valid & dec_ready;
    assign id_feed_ack = id_feed_req & ~empty & ~flush;
    assign pop         = id_feed_ack;

    assign wr_bundle = '{uop_0: dec_uop_0, uop_1: dec_uop_1, uop_2: dec_uop_2,
                         count: dec_uop_count, k16: dec_k16};

    // Entry storage needs no reset; validity is tracked by the pointers and occ.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_bundle;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        if (empty) begin
            head = '{uop_0: NOP, uop_1: NOP, uop_2: NOP, count: 2'd0, k16: 16'd0};
        end
    end

    assign id_uop_0     = head.uop_0;
    assign id_uop_1     = head.uop_1;
    assign id_uop_2     = head.uop_2;
    assign id_uop_count = head.count;
    assign id_k16       = head.k16;
    assign occupancy    = occ;

endmodule

// File: tb/tb_id_bundle_queue.sv
// Directed scoreboard bench for id_bundle_queue: model occupancy is the scoreboard depth.
module tb_id_bundle_queue;

    localparam int          DEPTH = 4;
    localparam int          PTR_W = 2;
    localparam logic [19:0] NOP   = 20'b0000_0000_1111_00_000_000;
    localparam logic [77:0] EMPTY_OUT = {NOP, NOP, NOP, 2'd0, 16'd0};

    logic             clk = 1'b0;
    logic             a_rst;
    logic             flush;
    logic             dec_valid;
    logic             dec_ready;
    logic [19:0]      dec_uop_0, dec_uop_1, dec_uop_2;
    logic [1:0]       dec_uop_count;
    logic [15:0]      dec_k16;
    logic             id_feed_req;
    logic             id_feed_ack;
    logic [19:0]      id_uop_0, id_uop_1, id_uop_2;
    logic [1:0]       id_uop_count;
    logic [15:0]      id_k16;
    logic [PTR_W:0]   occupancy;

    logic [77:0] sb[$];
    int          passed = 0;
    int          total  = 0;

    id_bundle_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .NOP(NOP)) dut (
        .clk(clk), .a_rst(a_rst), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_uop_0(dec_uop_0), .dec_uop_1(dec_uop_1), .dec_uop_2(dec_uop_2),
        .dec_uop_count(dec_uop_count), .dec_k16(dec_k16),
        .id_feed_req(id_feed_req), .id_feed_ack(id_feed_ack),
        .id_uop_0(id_uop_0), .id_uop_1(id_uop_1), .id_uop_2(id_uop_2),
        .id_uop_count(id_uop_count), .id_k16(id_k16),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [77:0] mk(input logic [1:0] cnt);
        logic [77:0] b;
        b = {20'($urandom), 20'($urandom), 20'($urandom), cnt, 16'($urandom)};
        return b;
    endfunction

    function automatic logic [77:0] out_bundle();
        return {id_uop_0, id_uop_1, id_uop_2, id_uop_count, id_k16};
    endfunction

    // Called just after a falling edge; drives one cycle, checks it, advances to the next falling edge.
    task automatic cycle(input logic v, input logic [77:0] b, input logic r, input logic f);
        logic        exp_rdy, exp_ack;
        logic [77:0] exp;
        int          n;
        dec_valid = v;
        {dec_uop_0, dec_uop_1, dec_uop_2, dec_uop_count, dec_k16} = b;
        id_feed_req = r;
        flush = f;
        #1;
        n = sb.size();
        exp_rdy = (n != DEPTH) && !f;
        exp_ack = r && (n != 0) && !f;
        chk("dec_ready", 78'(dec_ready), 78'(exp_rdy));
        chk("id_feed_ack", 78'(id_feed_ack), 78'(exp_ack));
        chk("occupancy", 78'(occupancy), 78'(n));
        if (n == 0) begin
            chk("empty_outputs", out_bundle(), EMPTY_OUT);
        end else if (exp_ack) begin
            exp = sb.pop_front();
            chk("head_bundle", out_bundle(), exp);
        end
        if (f) begin
            sb.delete();
        end else if (v && exp_rdy) begin
            sb.push_back(b);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [77:0] b;
        a_rst = 1'b0;
        flush = 1'b0;
        dec_valid = 1'b0;
        {dec_uop_0, dec_uop_1, dec_uop_2, dec_uop_count, dec_k16} = '0;
        id_feed_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ack", 78'(id_feed_ack), 78'(0));
        chk("rst_outputs", out_bundle(), EMPTY_OUT);
        chk("rst_ready", 78'(dec_ready), 78'(1));
        chk("rst_occupancy", 78'(occupancy), 78'(0));
        @(negedge clk);
        a_rst = 1'b1;

        // Idle with request asserted.
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        // Single bundle, offered one cycle after push.
        b = {20'h12345, 20'h0, 20'h0, 2'd2, 16'hBEEF};
        cycle(1'b1, b, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Fill to full, fifth push held, then drain in order.
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(2'(i)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push/pop at occupancy 2 across pointer wrap; count 3 passes through.
        cycle(1'b1, mk(2'd3), 1'b0, 1'b0);
        cycle(1'b1, mk(2'd1), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(2'(i)), 1'b1, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

        // Burst while full and popping: ready stays low that cycle, returns next.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(2'd0), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b1, mk(2'd3), 1'b1, 1'b0);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush at occupancy 3 with push and request asserted.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(2'd2), 1'b0, 1'b0);
        cycle(1'b1, mk(2'd1), 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, mk(2'd1), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset at occupancy 2.
        cycle(1'b1, mk(2'd1), 1'b0, 1'b0);
        cycle(1'b1, mk(2'd2), 1'b0, 1'b0);
        dec_valid = 1'b0;
        id_feed_req = 1'b1;
        a_rst = 1'b0;
        #1;
        sb.delete();
        chk("arst_outputs", out_bundle(), EMPTY_OUT);
        chk("arst_occupancy", 78'(occupancy), 78'(0));
        chk("arst_ack", 78'(id_feed_ack), 78'(0));
        @(negedge clk);
        #2;
        a_rst = 1'b1;
        @(negedge clk);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, mk(2'd3), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_bundle_queue.md
Name: id_bundle_queue

Overview:
- Decoupling FIFO between the instruction decoder and the reservation station.
- Stores decoded micro-op bundles: up to 3 uops, an extra-uop count and a 16-bit immediate.
- Serves bundles to the reservation station over its id_feed_req/id_feed_ack handshake.
- Absorbs decoder bursts and supports a synchronous flush on redirect (branch taken, interrupt entry).

Parameters:
- DEPTH, 4, number of bundle entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.
- NOP, 20'b0000_0000_1111_00_000_000, uop driven on empty outputs.

Ports:
- clk  input  1  clock
- a_rst  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous queue clear
- dec_valid  input  1  decoder presents a bundle
- dec_ready  output  1  queue accepts bundle this cycle
- dec_uop_0  input  20  first uop (executed last)
- dec_uop_1  input  20  second uop
- dec_uop_2  input  20  third uop
- dec_uop_count  input  2  extra uops beyond uop_0 (0..2)
- dec_k16  input  16  immediate/operand word
- id_feed_req  input  1  reservation station requests a bundle
- id_feed_ack  output  1  bundle on id_* outputs is being delivered
- id_uop_0  output  20  head bundle uop_0
- id_uop_1  output  20  head bundle uop_1
- id_uop_2  output  20  head bundle uop_2
- id_uop_count  output  2  head bundle count
- id_k16  output  16  head bundle immediate
- occupancy  output  PTR_W+1  entries held

Behaviour:
- Storage: DEPTH entries of 78 bits {uop_0, uop_1, uop_2, count, k16}; wr_ptr, rd_ptr, occ registers.
- Reset (a_rst low, asynchronous): wr_ptr=0, rd_ptr=0, occ=0. Entry contents need not be cleared.
- Reset effect on outputs: dec_ready=1, id_feed_ack=0, id_uop_0/1/2=NOP, id_uop_count=0, id_k16=0, occupancy=0.
- empty = (occ==0); full = (occ==DEPTH).
- dec_ready = ~full & ~flush. Registered state only; no dependence on id_feed_req, so no combinational path between the two interfaces.
- push = dec_valid & dec_ready: writes entry[wr_ptr] and increments wr_ptr (wraps modulo DEPTH).
- id_feed_ack = id_feed_req & ~empty & ~flush, combinational.
- pop = id_feed_ack: increments rd_ptr (wraps modulo DEPTH).
- id_* outputs: combinational from entry[rd_ptr] when not empty. When empty: NOP/NOP/NOP, count 0, k16 0.
- Data is valid on the same edge ack is high; the reservation station latches it on that edge.
- No bypass: a bundle pushed in cycle N is first offered in cycle N+1 (minimum latency 1 cycle).
- Occupancy update:
  - push only: occ+1.
  - pop only: occ-1.
  - push and pop together: occ unchanged, both pointers advance. Legal when 0<occ<DEPTH.
- Full with pop: dec_ready is still 0 that cycle; the freed slot becomes available the next cycle.
- Empty with push: ack stays 0 that cycle.
- Flush: next edge sets wr_ptr=rd_ptr=0 and occ=0. During a flush cycle there is no push and no pop, and any decoder bundle presented is dropped.
- Flush has priority over all other actions.
- Reset mid-operation: all entries are discarded immediately and the queue is empty on a_rst release.
- dec_uop_count is stored unmodified; the value 3 is stored and passed through.
- occupancy = occ, registered.

Test Plan:
- Reset then idle, id_feed_req=1 -> ack=0, id_uop_0=NOP, count=0, k16=0, dec_ready=1, occupancy=0.
- Push bundle {uop_0=20'h12345, count=2, k16=16'hBEEF} in cycle 0, req=1 -> ack=1 in cycle 1 with matching outputs; occupancy 1 then 0.
- Push 4 bundles with req=0 -> occupancy=4, dec_ready=0; a 5th push is held. Then req=1 for 4 cycles -> bundles returned in FIFO order; dec_ready=1 from the cycle after the first pop.
- Occupancy 2 with push and pop in the same cycle -> occupancy stays 2; pointer wrap verified over 10 bundles with no loss or reorder.
- Occupancy 3, flush=1 with dec_valid=1 and req=1 -> ack=0, dec_ready=0; next cycle occupancy=0 and outputs show NOP.
- a_rst pulsed low at occupancy 2 -> outputs immediately NOP, occupancy=0; no stale bundle delivered after release.
